// File: rtl/pwm_generator.sv
// Slew-limited 100-step PWM generator: duty requests are clamped to 100% and
// applied only at period boundaries, moving at most SLEW percent per period.
module pwm_generator #(
  parameter int unsigned CLK_DIV = 500,
  parameter int unsigned SLEW    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] dutyCycle,
  output logic       pwmOut,
  output logic [7:0] activeDuty,
  output logic       periodEnd,
  output logic       clamped
);

  localparam int unsigned DIV_W   = 16;
  localparam int unsigned PHASE_W = 7;
  localparam int unsigned DUTY_W  = 8;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(99);
  localparam logic [DUTY_W-1:0]  DUTY_MAX   = DUTY_W'(100);
  localparam logic [DUTY_W-1:0]  SLEW_STEP  = DUTY_W'(SLEW);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div;
  logic [DIV_W-1:0]    div_nxt;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phase_nxt;
  logic [DUTY_W-1:0]   duty_nxt;
  logic [DUTY_W-1:0]   target;
  logic [DUTY_W-1:0]   diff;
  logic [DUTY_W-1:0]   step;
  logic [DUTY_W-1:0]   slewed;
  logic                pwm_nxt;
  logic                period_end_nxt;
  logic                tick;
  logic                wrap;

  // Reset wins over everything; clamped tracks the raw request in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      phase      <= '0;
      activeDuty <= '0;
      pwmOut     <= 1'b0;
      periodEnd  <= 1'b0;
      clamped    <= 1'b0;
    end else begin
      state      <= state_nxt;
      div        <= div_nxt;
      phase      <= phase_nxt;
      activeDuty <= duty_nxt;
      pwmOut     <= pwm_nxt;
      periodEnd  <= period_end_nxt;
      clamped    <= (dutyCycle > DUTY_MAX);
    end
  end

  // Difference is taken before the compare so the unsigned math never wraps.
  always_comb begin
    target = (dutyCycle > DUTY_MAX) ? DUTY_MAX : dutyCycle;
    diff   = (target > activeDuty) ? (target - activeDuty) : (activeDuty - target);
    step   = ((SLEW == 0) || (diff < SLEW_STEP)) ? diff : SLEW_STEP;
    slewed = (target > activeDuty) ? (activeDuty + step) : (activeDuty - step);
  end

  always_comb begin
    state_nxt      = state;
    div_nxt        = '0;
    phase_nxt      = '0;
    duty_nxt       = '0;
    period_end_nxt = 1'b0;
    tick           = 1'b0;
    wrap           = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          tick           = (div == DIV_LAST);
          wrap           = tick && (phase == PHASE_LAST);
          div_nxt        = tick ? '0 : (div + DIV_W'(1));
          phase_nxt      = wrap ? '0 : (tick ? (phase + PHASE_W'(1)) : phase);
          duty_nxt       = wrap ? slewed : activeDuty;
          period_end_nxt = wrap;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pwm_nxt = ({1'b0, phase_nxt} < duty_nxt);
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator: a cycle-count reference model queues the
// expected result of each period, a monitor pops it on every periodEnd pulse.
module tb_pwm_generator;

  localparam int D   = 2;
  localparam int S   = 5;
  localparam int PER = 100 * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] duty_cycle = 8'd0;
  logic       pwm_out;
  logic [7:0] active_duty;
  logic       period_end;
  logic       clamped_o;

  always #5 clk = ~clk;

  pwm_generator #(.CLK_DIV(D), .SLEW(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .dutyCycle (duty_cycle),
    .pwmOut    (pwm_out),
    .activeDuty(active_duty),
    .periodEnd (period_end),
    .clamped   (clamped_o)
  );

  typedef struct {
    int duty;
    int high;
    int len;
  } per_t;

  per_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts cycles since the run started; period, step and duty
  // follow from plain arithmetic on that count.
  bit m_valid = 1'b0;
  bit m_run = 1'b0;
  bit m_start, m_pe, m_pwm, m_clamp;
  int m_cyc = 0;
  int m_duty = 0;
  int m_tgt, m_nd;

  always @(posedge clk) begin
    m_valid = 1'b1;
    m_start = 1'b0;
    m_pe    = 1'b0;
    m_clamp = rst_n && (duty_cycle > 8'd100);
    if (!rst_n || !enable) begin
      m_run = 1'b0; m_cyc = 0; m_duty = 0; m_pwm = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1; m_cyc = 0; m_duty = 0; m_pwm = 1'b0; m_start = 1'b1;
    end else begin
      m_cyc++;
      if (m_cyc % PER == 0) begin
        m_tgt = (duty_cycle > 8'd100) ? 100 : int'(duty_cycle);
        if (S == 0)               m_nd = m_tgt;
        else if (m_tgt > m_duty)  m_nd = m_duty + ((m_tgt - m_duty) < S ? (m_tgt - m_duty) : S);
        else                      m_nd = m_duty - ((m_duty - m_tgt) < S ? (m_duty - m_tgt) : S);
        sb.push_back('{duty: m_nd, high: m_duty * D, len: PER});
        m_duty = m_nd;
        m_pe = 1'b1;
      end
      m_pwm = ((m_cyc / D) % 100) < m_duty;
    end
  end

  // Monitor: per-cycle comparison plus per-period scoreboard pop on periodEnd.
  int mon_len = 0;
  int mon_high = 0;
  per_t e;

  always @(negedge clk) begin
    if (m_valid) begin
      check("pwmOut", pwm_out, m_pwm);
      check("activeDuty", active_duty, m_duty);
      check("periodEnd", period_end, m_pe);
      check("clamped", clamped_o, m_clamp);
      if (m_start) begin
        mon_len = 0; mon_high = 0;
      end
      if (period_end) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("period_duty", active_duty, e.duty);
          check("period_high", mon_high, e.high);
          check("period_len", mon_len, e.len);
        end
        mon_len = 0; mon_high = 0;
      end
      mon_len++;
      mon_high += int'(pwm_out);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pe();
    for (int k = 0; k < 2 * PER + 4; k++) begin
      @(negedge clk);
      if (period_end) break;
    end
    check("pe_timeout", period_end, 1);
  endtask

  task automatic count_level(input int n, input bit lvl, output int hits);
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out == lvl) hits++;
    end
  endtask

  int hits;
  int r;

  initial begin
    // Reset held with enable asserted
    rst_n = 1'b0; enable = 1'b1; duty_cycle = 8'd50;
    cycles(3);
    check("rst_pwm", pwm_out, 0);
    check("rst_duty", active_duty, 0);
    check("rst_pe", period_end, 0);
    check("rst_clamped", clamped_o, 0);

    // Ramp up to 20
    rst_n = 1'b1; duty_cycle = 8'd20;
    count_level(PER - 2, 1'b1, hits);
    check("first_period_low", hits, 0);
    for (int k = 1; k <= 6; k++) begin
      wait_pe();
      check("ramp", active_duty, (k <= 4) ? 5 * k : 20);
    end

    // Extremes
    @(posedge clk); #2;
    duty_cycle = 8'd100;
    repeat (17) wait_pe();
    check("settle_100", active_duty, 100);
    count_level(3 * PER, 1'b0, hits);
    check("const_high", hits, 0);
    @(posedge clk); #2;
    duty_cycle = 8'd0;
    repeat (20) wait_pe();
    check("settle_0", active_duty, 0);
    count_level(3 * PER, 1'b1, hits);
    check("const_low", hits, 0);

    // Clamp
    @(posedge clk); #2;
    duty_cycle = 8'd150;
    @(posedge clk); @(negedge clk);
    check("clamp_set", clamped_o, 1);
    repeat (22) wait_pe();
    check("clamp_sat", active_duty, 100);
    @(posedge clk); #2;
    duty_cycle = 8'd90;
    @(posedge clk); @(negedge clk);
    check("clamp_clr", clamped_o, 0);
    repeat (2) wait_pe();
    check("down_90", active_duty, 90);

    // Mid-period change
    @(posedge clk); #2;
    duty_cycle = 8'd20;
    repeat (15) wait_pe();
    check("settle_20", active_duty, 20);
    repeat (100) @(posedge clk);
    #2;
    duty_cycle = 8'd60;
    wait_pe();
    check("mid_next", active_duty, 25);

    // Enable dropped at phase 30
    wait_pe();
    cycles(60);
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_pwm", pwm_out, 0);
    check("abort_duty", active_duty, 0);
    cycles(4);
    enable = 1'b1;
    wait_pe();
    check("restart", active_duty, 5);

    // Reset pulse mid-period
    wait_pe();
    cycles(60);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rstp_pwm", pwm_out, 0);
    check("rstp_duty", active_duty, 0);
    rst_n = 1'b1;
    wait_pe();
    check("rstp_restart", active_duty, 5);

    // Enable dropped on the wrap edge
    wait_pe();
    repeat (PER - 1) @(posedge clk);
    #2;
    enable = 1'b0;
    @(posedge clk); @(negedge clk);
    check("wrap_drop_pe", period_end, 0);
    check("wrap_drop_duty", active_duty, 0);
    @(posedge clk); #2;
    enable = 1'b1;

    // Randomized requests, aborts and resets
    for (int it = 0; it < 25; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) duty_cycle = 8'($urandom_range(101, 255));
      else        duty_cycle = 8'(10 * $urandom_range(0, 10));
      cycles(int'($urandom_range(1, 3)) * PER + int'($urandom_range(0, PER - 1)));
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        enable = 1'b0; cycles(int'($urandom_range(1, 5))); enable = 1'b1;
      end else if (r == 1) begin
        rst_n = 1'b0; cycles(1); rst_n = 1'b1;
      end
    end

    cycles(5);
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Downstream stage of the switch-driven duty-cycle counter. It consumes the 8-bit percentage `dutyCycle` (0–100, steps of 10), clamps it, and slew-limits changes so they apply only at PWM period boundaries. It drives a single PWM output with a fixed 100-step period derived from a clock prescaler. It also reports the duty actually in force and a period-end strobe for downstream logic.

## Interface

Parameters:
- `CLK_DIV`, default 500: `clk` cycles per PWM step. Legal range 1..65535.
- `SLEW`, default 10: maximum change of `activeDuty` per period, in percent. The value 0 disables limiting, so `activeDuty` jumps straight to the target.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, **synchronous, active-low**.
- `enable`, input, 1: run/stop.
- `dutyCycle`, input, 8: requested duty in percent. Can change at any time.
- `pwmOut`, output, 1: PWM waveform, registered.
- `activeDuty`, output, 8: duty applied in the current period (0..100), registered.
- `periodEnd`, output, 1: one-cycle pulse on the edge where the step counter wraps.
- `clamped`, output, 1: registered flag, 1 while `dutyCycle > 100`.

## Operation

- States:
  - IDLE: entered from reset, or from any state when `enable` = 0.
  - RUN: entered from IDLE when `enable` = 1 is sampled.
- Prescaler `div` runs 0..CLK_DIV-1. A step tick occurs on the edge where `div` = CLK_DIV-1; `div` then returns to 0.
- Step counter `phase` runs 0..99 and advances only on a tick. The tick at `phase` = 99 sets `phase` to 0 and fires the wrap.
- Target: `target` = min(`dutyCycle`, 100), evaluated combinationally. `clamped` <= (`dutyCycle` > 100) every cycle, in all states.
- On wrap only, `activeDuty` moves toward `target`:
  - If `target` > `activeDuty`: add min(SLEW, difference).
  - If `target` < `activeDuty`: subtract min(SLEW, difference).
  - If equal: hold.
  - With SLEW = 0: `activeDuty` <= `target`.
- Changes to `dutyCycle` mid-period have no effect until the next wrap.
- `pwmOut` = (`phase` < `activeDuty`), computed from the next-state values of `phase` and `activeDuty` and registered. `pwmOut` is therefore aligned with the registered counters.
- Boundary cases:
  - `activeDuty` = 0: `pwmOut` stays low for the whole period.
  - `activeDuty` = 100: `pwmOut` stays high, with no glitch at the wrap.
- Arithmetic widths: `phase` is 7 bits and `activeDuty` is 8 bits. Slew arithmetic is done on unsigned 8-bit values, with the difference computed before the compare, so no underflow can occur.
- IDLE behaviour: `div`, `phase`, `activeDuty`, `pwmOut` and `periodEnd` are all held at 0. Every re-enable therefore soft-starts from 0%.

## Timing

- Reset values (edge with `rst_n` = 0): `pwmOut` = 0, `activeDuty` = 0, `periodEnd` = 0, `clamped` = 0, `div` = 0, `phase` = 0, state = IDLE.
- Reset takes priority over `enable`.
- Asserting reset mid-period clears everything on that edge. No partial period is completed.
- Period length: 100 × CLK_DIV cycles, exactly.
- IDLE to RUN: on the edge `enable` = 1 is sampled, the state becomes RUN with `phase` = 0 and `div` = 0. The first period runs at `activeDuty` = 0.
- `periodEnd` and the `activeDuty` update occur on the same edge that `phase` goes 99 to 0. `pwmOut` reflects the new duty from that same edge.
- Dropping `enable` while in RUN: on the next edge, `pwmOut` = 0 and all counters are 0.
- If `enable` drops on the wrap edge, IDLE wins: `periodEnd` = 0 and `activeDuty` = 0.
- Pulse-high length per period: `activeDuty` × CLK_DIV cycles.

## Test plan

All scenarios use CLK_DIV = 2 and SLEW = 5.

- Reset: hold `rst_n` = 0 for 3 cycles with `enable` = 1 and `dutyCycle` = 50. Required: all outputs 0. After release, `pwmOut` stays 0 for the first 200 cycles.
- Ramp up: `enable` = 1, `dutyCycle` = 20. Required:
  - `activeDuty` reads 5, 10, 15, 20 after successive `periodEnd` pulses, then holds at 20.
  - Once settled, `pwmOut` is high for 40 of every 200 cycles.
  - `periodEnd` pulses exactly every 200 cycles.
- Extremes:
  - Settled at 100: `pwmOut` stays constantly high across 3 wraps.
  - Then set `dutyCycle` = 0: `activeDuty` steps down by 5 per period to 0, after which `pwmOut` stays constantly low.
- Clamp: `dutyCycle` = 150. Required: `clamped` = 1 on the next edge, and `activeDuty` saturates at 100, never exceeding it. Setting `dutyCycle` = 90 returns `clamped` to 0 one cycle later.
- Mid-period change: settled at 20, switch `dutyCycle` to 60 at `phase` = 50. Required: the current period still gives 40 high cycles, and the next period gives `activeDuty` = 25.
- Abort:
  - `enable` dropped at `phase` = 30: required `pwmOut` = 0 and `activeDuty` = 0 on the next edge. On re-enable, the ramp restarts from 0.
  - `rst_n` pulsed low for 1 cycle mid-period: same result.
